// File: rtl/tick_source.sv
// tick_source: seconds timebase with a debounced minute-advance button.
// A prescaler divides clk down to one tick_1s per second and a 0..59
// seconds counter emits tick_1m on its wrap. The button path (2-flop
// synchronizer, debouncer, IDLE/PRESS/REPEAT FSM) emits tick_1m on press
// and auto-repeats while held; timekeeping is parked at zero meanwhile.
module tick_source #(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned DEB_CYC  = 1000000,
  parameter int unsigned HOLD_CYC = 50000000,
  parameter int unsigned RPT_CYC  = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       btn_adv,
  output logic       tick_1s,
  output logic [5:0] seconds,
  output logic       tick_1m
);

  // Counter widths, each guarded so a terminal count of 1 still gets a bit.
  localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned HMAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int unsigned HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] R_LAST = HW'(RPT_CYC - 1);
  localparam logic [5:0]    S_LAST = 6'd59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [HW-1:0] hcnt;

  logic          sync1;
  logic          sync2;
  logic          deb_lvl;
  logic [DW-1:0] dcnt;

  logic          deb_hit;
  logic          deb_rise;
  logic          deb_fall;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_adv;
      sync2 <= sync1;
    end
  end

  // Debouncer: adopt the synchronized level after DEB_CYC consecutive
  // cycles of disagreement with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_lvl <= 1'b0;
      dcnt    <= '0;
    end else if (sync2 != deb_lvl) begin
      if (dcnt == D_LAST) begin
        deb_lvl <= sync2;
        dcnt    <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end else begin
      dcnt <= '0;
    end
  end

  // Acceptance events are decoded from the debouncer's pre-edge state so the
  // FSM reacts on the very edge the new level is accepted.
  always_comb begin
    deb_hit  = (sync2 != deb_lvl) && (dcnt == D_LAST);
    deb_rise = deb_hit && sync2;
    deb_fall = deb_hit && !sync2;
  end

  // Timekeeping and button FSM share one block: the press pulse and the
  // natural minute wrap drive the same registered tick_1m, so coincident
  // events collapse into a single pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pcnt    <= '0;
      hcnt    <= '0;
      seconds <= '0;
      tick_1s <= 1'b0;
      tick_1m <= 1'b0;
    end else begin
      tick_1s <= 1'b0;
      tick_1m <= 1'b0;
      case (state)
        IDLE: begin
          if (deb_rise) begin
            state   <= PRESS;
            hcnt    <= '0;
            pcnt    <= '0;
            seconds <= '0;
            tick_1m <= 1'b1;
          end else if (run) begin
            if (pcnt == P_LAST) begin
              pcnt    <= '0;
              tick_1s <= 1'b1;
              if (seconds == S_LAST) begin
                seconds <= '0;
                tick_1m <= 1'b1;
              end else begin
                seconds <= seconds + 6'd1;
              end
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
        end

        PRESS: begin
          pcnt    <= '0;
          seconds <= '0;
          if (deb_fall) begin
            state <= IDLE;
            hcnt  <= '0;
          end else if (hcnt == H_LAST) begin
            state   <= REPEAT;
            hcnt    <= '0;
            tick_1m <= 1'b1;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end

        REPEAT: begin
          pcnt    <= '0;
          seconds <= '0;
          if (deb_fall) begin
            state <= IDLE;
            hcnt  <= '0;
          end else if (hcnt == R_LAST) begin
            hcnt    <= '0;
            tick_1m <= 1'b1;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end

        default: begin
          state <= IDLE;
          hcnt  <= '0;
          pcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_source.sv
// Testbench for tick_source with a small timebase. A cycle-stepped
// behavioural model (elapsed-time arithmetic, press age, sample history)
// predicts the outputs; a compare process checks them every cycle, and
// directed scenarios add literal expectations at key instants.
module tb_tick_source;

  localparam int CLK_HZ   = 4;
  localparam int DEB_CYC  = 2;
  localparam int HOLD_CYC = 8;
  localparam int RPT_CYC  = 4;

  logic       clk;
  logic       rst;
  logic       run;
  logic       btn_adv;
  logic       tick_1s;
  logic [5:0] seconds;
  logic       tick_1m;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n1s   = 0;
  int n1m   = 0;

  tick_source #(
    .CLK_HZ  (CLK_HZ),
    .DEB_CYC (DEB_CYC),
    .HOLD_CYC(HOLD_CYC),
    .RPT_CYC (RPT_CYC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .btn_adv(btn_adv),
    .tick_1s(tick_1s),
    .seconds(seconds),
    .tick_1m(tick_1m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: elapsed running cycles since last zeroing, press age,
  // raw button history and the accepted (debounced) level.
  int   m_elapsed = 0;
  int   m_age     = 0;
  int   m_len     = 0;
  bit   m_pressed = 0;
  bit   m_acc     = 0;
  bit   m_h0      = 0;
  bit   m_h1      = 0;
  bit   e1s       = 0;
  bit   e1m       = 0;
  int   e_sec     = 0;
  bit   armed     = 0;
  logic prev_1m   = 1'b0;

  // Per-cycle compare, then advance the model to the next rising edge
  // using the inputs that edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        chk("tick_1s", {7'd0, tick_1s}, {7'd0, e1s});
        chk("tick_1m", {7'd0, tick_1m}, {7'd0, e1m});
        chk("seconds", {2'd0, seconds}, 8'(e_sec));
        chk("no_b2b_tick_1m", {7'd0, prev_1m & tick_1m}, 8'd0);
        prev_1m = tick_1m;
      end
      e1s = 0;
      e1m = 0;
      if (rst) begin
        m_elapsed = 0; m_age = 0; m_len = 0;
        m_pressed = 0; m_acc = 0; m_h0 = 0; m_h1 = 0;
        prev_1m   = 1'b0;
        armed     = 1;
      end else begin
        bit synced, rise, fall;
        synced = m_h1;
        m_h1   = m_h0;
        m_h0   = btn_adv;
        rise = 0;
        fall = 0;
        if (synced != m_acc) begin
          m_len++;
          if (m_len == DEB_CYC) begin
            m_acc = synced;
            m_len = 0;
            rise  = synced;
            fall  = !synced;
          end
        end else begin
          m_len = 0;
        end
        if (!m_pressed) begin
          if (rise) begin
            m_pressed = 1; m_age = 0; m_elapsed = 0; e1m = 1;
          end else if (run) begin
            m_elapsed++;
            if (m_elapsed % CLK_HZ == 0) begin
              e1s = 1;
              if (m_elapsed == CLK_HZ * 60) begin
                e1m = 1;
                m_elapsed = 0;
              end
            end
          end
        end else begin
          if (fall) begin
            m_pressed = 0; m_elapsed = 0;
          end else begin
            m_age++;
            if (m_age == HOLD_CYC ||
                (m_age > HOLD_CYC && (m_age - HOLD_CYC) % RPT_CYC == 0))
              e1m = 1;
          end
        end
      end
      e_sec = m_elapsed / CLK_HZ;
    end
  end

  // Pulse counters sampled just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_1s === 1'b1) n1s++;
      if (tick_1m === 1'b1) n1m++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr();
    n1s = 0;
    n1m = 0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; btn_adv = 1'b0;
    tick(3);
    chk("reset_seconds", {2'd0, seconds}, 8'd0);
    chk("reset_tick_1s", {7'd0, tick_1s}, 8'd0);
    chk("reset_tick_1m", {7'd0, tick_1m}, 8'd0);

    // Free run for one full minute.
    rst = 1'b0; run = 1'b1; clr();
    tick(240);
    chk("minute_n1s", 8'(n1s), 8'd60);
    chk("minute_n1m", 8'(n1m), 8'd1);
    chk("minute_seconds", {2'd0, seconds}, 8'd0);
    chk("minute_wrap_1s", {7'd0, tick_1s}, 8'd1);
    chk("minute_wrap_1m", {7'd0, tick_1m}, 8'd1);

    // Pause at seconds=30.
    tick(120);
    chk("model_sec30", 8'(e_sec), 8'd30);
    run = 1'b0; clr();
    tick(20);
    chk("pause_seconds", {2'd0, seconds}, 8'd30);
    chk("pause_ticks", 8'(n1s + n1m), 8'd0);
    run = 1'b1; clr();
    tick(3);
    chk("resume_early", 8'(n1s), 8'd0);
    tick(1);
    chk("resume_tick", 8'(n1s), 8'd1);
    chk("resume_seconds", {2'd0, seconds}, 8'd31);

    // Short press at seconds=42.
    tick(44);
    chk("pre_press_seconds", {2'd0, seconds}, 8'd42);
    btn_adv = 1'b1; clr();
    tick(3);
    chk("press_latency_early", 8'(n1m), 8'd0);
    tick(1);
    chk("press_pulse", 8'(n1m), 8'd1);
    chk("press_seconds", {2'd0, seconds}, 8'd0);
    tick(2);
    btn_adv = 1'b0; clr();
    tick(4);
    chk("release_no_pulse", 8'(n1m), 8'd0);
    chk("release_seconds", {2'd0, seconds}, 8'd0);
    tick(4);
    chk("after_release_n1s", 8'(n1s), 8'd1);
    chk("after_release_seconds", {2'd0, seconds}, 8'd1);

    // Long hold: pulses at +4, +12, then every 4 until release.
    tick(0);
    m_len = m_len; // keep model untouched
    btn_adv = 1'b1; clr();
    tick(4);
    chk("hold_first", 8'(n1m), 8'd1);
    chk("hold_no_1s", 8'(n1s), 8'd0);
    tick(7);
    chk("hold_gap", 8'(n1m), 8'd1);
    tick(1);
    chk("hold_second", 8'(n1m), 8'd2);
    chk("model_age8", 8'(m_age), 8'd8);
    tick(18);
    chk("hold_repeats", 8'(n1m), 8'd6);
    btn_adv = 1'b0;
    tick(4);
    chk("hold_total", 8'(n1m), 8'd7);

    // One-cycle glitch is rejected.
    clr();
    btn_adv = 1'b1;
    tick(1);
    btn_adv = 1'b0;
    tick(7);
    chk("glitch_n1m", 8'(n1m), 8'd0);
    chk("glitch_seconds", {2'd0, seconds}, 8'd2);

    // Press lands on the 59->0 wrap.
    tick(228);
    chk("pre_wrap_seconds", {2'd0, seconds}, 8'd59);
    btn_adv = 1'b1; clr();
    tick(4);
    chk("wrap_press_n1m", 8'(n1m), 8'd1);
    chk("wrap_press_seconds", {2'd0, seconds}, 8'd0);
    chk("wrap_press_1m", {7'd0, tick_1m}, 8'd1);
    tick(10);
    chk("repeat_reached", 8'(n1m), 8'd2);

    // Reset while in REPEAT with the button still held.
    rst = 1'b1;
    tick(1);
    chk("rst_tick_1m", {7'd0, tick_1m}, 8'd0);
    chk("rst_tick_1s", {7'd0, tick_1s}, 8'd0);
    chk("rst_seconds", {2'd0, seconds}, 8'd0);
    rst = 1'b0; clr();
    tick(3);
    chk("post_rst_early", 8'(n1m), 8'd0);
    tick(1);
    chk("post_rst_pulse", 8'(n1m), 8'd1);
    tick(4);
    btn_adv = 1'b0;
    tick(4);
    chk("release_on_hold_expiry", 8'(n1m), 8'd1);
    clr();
    tick(4);
    chk("final_n1s", 8'(n1s), 8'd1);
    chk("final_seconds", {2'd0, seconds}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_source.md
TICK_SOURCE -- requirements
Module: tick_source

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- CLK_HZ, 100000000, clk cycles per second.
- DEB_CYC, 1000000, cycles btn_adv must be stable before acceptance.
- HOLD_CYC, 50000000, debounced-press cycles before auto-repeat starts.
- RPT_CYC, 10000000, cycles between auto-repeat pulses.

REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk, in, 1, clock; all logic is on the rising edge.
- rst, in, 1, reset: synchronous, active-high.
- run, in, 1, 1 = timekeeping advances; 0 = paused.
- btn_adv, in, 1, raw asynchronous minute-advance button, active-high.
- tick_1s, out, 1, one-cycle pulse per elapsed second.
- seconds, out, 6, current seconds value, 0..59.
- tick_1m, out, 1, one-cycle minute-advance pulse for the downstream minutes counter.

Function
REQ-003 The prescaler pcnt SHALL be a counter of width ceil(log2(CLK_HZ)), counting 0..CLK_HZ-1, incrementing only when run=1 and the FSM is IDLE.
REQ-004 On the edge where pcnt==CLK_HZ-1 and it increments, pcnt SHALL become 0 and tick_1s SHALL be registered 1 for exactly one cycle; otherwise tick_1s SHALL be 0.
REQ-005 seconds SHALL advance on that same edge: +1 if below 59, or 59->0 with tick_1m registered 1 for one cycle.
REQ-006 With run=0, pcnt and seconds SHALL hold, and tick_1s and tick_1m SHALL be 0.
REQ-007 btn_adv SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after the synchronized level differs from the accepted level for DEB_CYC consecutive cycles.
- Debounced latency = 2 + DEB_CYC cycles.
REQ-008 The FSM SHALL have states IDLE, PRESS, REPEAT, with a hold/repeat counter hcnt.
REQ-009 IDLE->PRESS SHALL occur on a debounced rising edge; on that edge:
- tick_1m is registered 1 for one cycle;
- pcnt=0, seconds=0, hcnt=0.
REQ-010 In PRESS, hcnt SHALL increment each cycle; on hcnt==HOLD_CYC-1 the FSM SHALL go to REPEAT, emit one tick_1m pulse and clear hcnt.
REQ-011 In REPEAT, hcnt SHALL count 0..RPT_CYC-1; each wrap SHALL emit one tick_1m pulse.
REQ-012 In PRESS or REPEAT, a debounced release SHALL return the FSM to IDLE with no pulse on that edge; counting SHALL resume from pcnt=0, seconds=0.
REQ-013 While not IDLE, pcnt and seconds SHALL be held at 0 and tick_1s SHALL be 0, regardless of run.
REQ-014 Button pulses SHALL be generated independent of run.
REQ-015 If the natural 59->0 wrap and the IDLE->PRESS pulse fall on the same edge, exactly one tick_1m pulse SHALL be emitted and seconds SHALL become 0.
REQ-016 tick_1m SHALL never be high on two consecutive cycles; all outputs SHALL be registered.

Reset
REQ-017 While rst=1 the following SHALL all be 0 on the next edge, overriding every other condition including mid-press and mid-repeat:
- pcnt, seconds, hcnt, tick_1s, tick_1m;
- synchronizer flops, debouncer counter and accepted level;
- FSM, which returns to IDLE.
REQ-018 After rst is released with btn_adv held high, the button SHALL be treated as a new press after debounce and emit exactly one tick_1m pulse.

Verification
REQ-019 The bench SHALL use CLK_HZ=4, DEB_CYC=2, HOLD_CYC=8, RPT_CYC=4 and cover:
- Run=1 for 240 cycles after reset: 60 tick_1s pulses 4 cycles apart, seconds 0..59 then 0, exactly one tick_1m, coincident with the 59->0 tick_1s.
- Run=0 for 20 cycles at seconds=30: seconds stays 30, no ticks; run=1: next tick_1s 4 cycles later.
- Single btn_adv press of 6 cycles at seconds=42: one tick_1m 4 cycles after press; seconds=0 and held until release, then count resumes.
- btn_adv held 30 cycles: first pulse at press+4, second 8 cycles later, then every 4 cycles until debounced release; no back-to-back pulses.
- Glitch of 1 cycle on btn_adv: no pulse, no state change; press timed onto the seconds=59 wrap: exactly one tick_1m.
- rst asserted while in REPEAT: all outputs 0 next cycle; with btn still held, exactly one new pulse after debounce.
